// File: rtl/pu_seq_if.sv
// Instruction-fetch handshake bundle between the PU sequencer and instruction memory.
// Latency: none, plain wires. Backpressure: imem_req holds with a stable address until imem_rdy.
// Ports: master = sequencer (drives req/addr), slave = memory (drives rdy/data).
interface pu_seq_if #(
  parameter int PCW  = 8,
  parameter int CMDW = 16
);
  logic            imem_req;
  logic [PCW-1:0]  imem_addr;
  logic            imem_rdy;
  logic [CMDW-1:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_rdy, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_rdy, output imem_data);
endinterface

// File: rtl/pu_seq.sv
// Fetch/execute/writeback sequencer for the 16-bit PU: owns PC and IR, gates the RF write.
// Latency: 3 cycles per instruction with zero-wait fetch, 2+MULLAT for register-form MUL.
// Backpressure: FETCH holds imem_req with a stable address for as long as imem_rdy stays low.
// Ports: clk/rst/start control; imem fetch bundle (master side); ir out to the decoder;
//        dec_h/dec_we in from the decoder; rf_we gated write; pc, busy, halted, retired status.
module pu_seq #(
  parameter int PCW    = 8,
  parameter int CMDW   = 16,
  parameter int MULLAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  pu_seq_if.master        imem,
  output logic [CMDW-1:0] ir,
  input  logic            dec_h,
  input  logic            dec_we,
  output logic            rf_we,
  output logic [PCW-1:0]  pc,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // The counter is loaded on the FETCH->EXEC edge and EXEC leaves when it reads zero,
  // so loading MULLAT-1 yields exactly MULLAT EXEC cycles.
  localparam logic [3:0]     MUL_CNT = 4'(MULLAT - 1);
  localparam logic [PCW-1:0] PC_ONE  = PCW'(1);

  state_t          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [CMDW-1:0] ir_q, ir_d;
  logic [3:0]      mcnt_q, mcnt_d;
  logic [15:0]     retired_q, retired_d;
  logic            is_mul;

  // Register-form MUL: opcode 0001 with function nibble 1100; immediate forms take 1 cycle.
  assign is_mul = (imem.imem_data[15:12] == 4'b0001) && (imem.imem_data[7:4] == 4'b1100);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mcnt_d    = mcnt_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem.imem_rdy) begin
          ir_d    = imem.imem_data;
          mcnt_d  = is_mul ? MUL_CNT : 4'd0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (mcnt_q != 4'd0) mcnt_d = mcnt_q - 4'd1;
        else                state_d = S_WB;
      end
      S_WB: begin
        if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
        // HALT leaves pc on the HALT word so software can see where it stopped.
        if (dec_h) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_q + PC_ONE;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      mcnt_q    <= 4'd0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mcnt_q    <= mcnt_d;
      retired_q <= retired_d;
    end
  end

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign ir             = ir_q;
  assign pc             = pc_q;
  // Only WB can write, and WB lasts one cycle, so each writing instruction pulses once.
  assign rf_we          = (state_q == S_WB) & dec_we & ~dec_h;
  assign busy           = (state_q == S_FETCH) | (state_q == S_EXEC) | (state_q == S_WB);
  assign halted         = (state_q == S_HALT);
  assign retired        = retired_q;

endmodule

// File: tb/tb_pu_seq.sv
module tb_pu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  always #5 clk = ~clk;

  // DUT A: PCW=8, MULLAT=3
  pu_seq_if #(.PCW(8), .CMDW(16)) ifa ();
  logic [15:0] ir_a;
  logic        dec_h_a, dec_we_a, rf_we_a, busy_a, halted_a;
  logic [7:0]  pc_a;
  logic [15:0] retired_a;

  pu_seq #(.PCW(8), .CMDW(16), .MULLAT(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .imem(ifa),
    .ir(ir_a), .dec_h(dec_h_a), .dec_we(dec_we_a), .rf_we(rf_we_a),
    .pc(pc_a), .busy(busy_a), .halted(halted_a), .retired(retired_a)
  );

  // DUT B: PCW=2 for the wrap test
  pu_seq_if #(.PCW(2), .CMDW(16)) ifb ();
  logic [15:0] ir_b;
  logic        dec_h_b, dec_we_b, rf_we_b, busy_b, halted_b;
  logic [1:0]  pc_b;
  logic [15:0] retired_b;

  pu_seq #(.PCW(2), .CMDW(16), .MULLAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .imem(ifb),
    .ir(ir_b), .dec_h(dec_h_b), .dec_we(dec_we_b), .rf_we(rf_we_b),
    .pc(pc_b), .busy(busy_b), .halted(halted_b), .retired(retired_b)
  );

  // Tiny decoder model: opcode F = HALT, 0 = NOP, anything else writes the RF.
  assign dec_h_a  = (ir_a[15:12] == 4'hF);
  assign dec_we_a = (ir_a[15:12] != 4'h0) && (ir_a[15:12] != 4'hF);
  assign dec_h_b  = (ir_b[15:12] == 4'hF);
  assign dec_we_b = (ir_b[15:12] != 4'h0) && (ir_b[15:12] != 4'hF);

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [4];
  int wait_addr = -1;
  int wait_n    = 0;
  int wcnt_a    = 0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Memory models, updated on the falling edge.
  initial begin
    ifa.imem_rdy = 1'b0; ifa.imem_data = '0;
    ifb.imem_rdy = 1'b0; ifb.imem_data = '0;
    forever begin
      @(negedge clk);
      if (ifa.imem_req) begin
        if (wcnt_a >= ((int'(ifa.imem_addr) == wait_addr) ? wait_n : 0)) begin
          ifa.imem_rdy  = 1'b1;
          ifa.imem_data = mem_a[ifa.imem_addr];
          wcnt_a        = 0;
        end else begin
          ifa.imem_rdy  = 1'b0;
          ifa.imem_data = 16'hDEAD;
          wcnt_a++;
        end
      end else begin
        ifa.imem_rdy  = 1'b0;
        ifa.imem_data = 16'hDEAD;
        wcnt_a        = 0;
      end
      ifb.imem_rdy  = ifb.imem_req;
      ifb.imem_data = mem_b[ifb.imem_addr];
    end
  end

  // Scoreboard for DUT A writes plus fetch-entry log.
  logic [15:0] exp_wr [$];
  int          fpc_q  [$];
  int          fcyc_q [$];
  int          cyc      = 0;
  int          n_wr     = 0;
  logic        req_prev = 1'b0;

  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (ifa.imem_req && !req_prev) begin
      fpc_q.push_back(int'(pc_a));
      fcyc_q.push_back(cyc);
    end
    req_prev = ifa.imem_req;
    if (rf_we_a) begin
      n_wr++;
      if (exp_wr.size() == 0) chk("wr_unexpected", 32'(ir_a), 32'hFFFF_FFFF);
      else chk("wr_ir", 32'(ir_a), 32'(exp_wr.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    fpc_q.delete();
    fcyc_q.delete();
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (!halted_a && n < budget) begin
      tick();
      n++;
    end
    if (!halted_a) chk("halt_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_a(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    for (int i = 0; i < 256; i++) mem_a[i] = 16'hF000;
    mem_a[0] = w0; mem_a[1] = w1; mem_a[2] = w2;
  endtask

  initial begin
    int n_wr0;
    int bpcs [$];
    int bwr;
    logic bprev;

    tick();
    do_reset();
    rst = 1'b1; tick();
    // reset values
    chk("rst_req",     32'(ifa.imem_req), 32'd0);
    chk("rst_rf_we",   32'(rf_we_a),      32'd0);
    chk("rst_busy",    32'(busy_a),       32'd0);
    chk("rst_halted",  32'(halted_a),     32'd0);
    chk("rst_pc",      32'(pc_a),         32'd0);
    chk("rst_ir",      32'(ir_a),         32'd0);
    chk("rst_retired", 32'(retired_a),    32'd0);
    rst = 1'b0; tick();

    // 1: LI r1,5 ; NOP ; HALT with zero-wait memory
    do_reset();
    load_a(16'h2105, 16'h0000, 16'hF000);
    exp_wr.push_back(16'h2105);
    n_wr0 = n_wr;
    pulse_start_a();
    wait_halt(50);
    chk("p1_pc",      32'(pc_a),       32'd2);
    chk("p1_halted",  32'(halted_a),   32'd1);
    chk("p1_retired", 32'(retired_a),  32'd3);
    chk("p1_writes",  32'(n_wr - n_wr0), 32'd1);
    chk("p1_nfetch",  32'(fpc_q.size()), 32'd3);
    if (fpc_q.size() >= 3) begin
      chk("p1_fpc0", 32'(fpc_q[0]), 32'd0);
      chk("p1_fpc1", 32'(fpc_q[1]), 32'd1);
      chk("p1_fpc2", 32'(fpc_q[2]), 32'd2);
      chk("p1_gap0", 32'(fcyc_q[1] - fcyc_q[0]), 32'd3);
      chk("p1_gap1", 32'(fcyc_q[2] - fcyc_q[1]), 32'd3);
    end
    // HALT holds
    tick(); tick(); tick();
    chk("p1_hold_halt", 32'(halted_a), 32'd1);
    chk("p1_hold_pc",   32'(pc_a),     32'd2);
    chk("p1_hold_req",  32'(ifa.imem_req), 32'd0);

    // 2: fetch ready delayed 4 cycles on address 0
    do_reset();
    load_a(16'h2105, 16'hF000, 16'hF000);
    wait_addr = 0; wait_n = 4;
    exp_wr.push_back(16'h2105);
    pulse_start_a();
    for (int i = 0; i < 5; i++) begin
      chk("dly_req",  32'(ifa.imem_req),  32'd1);
      chk("dly_addr", 32'(ifa.imem_addr), 32'd0);
      chk("dly_ir",   32'(ir_a),          32'd0);
      tick();
    end
    chk("dly_req_off", 32'(ifa.imem_req), 32'd0);
    chk("dly_ir_load", 32'(ir_a),         32'h2105);
    wait_halt(50);
    wait_addr = -1; wait_n = 0;
    chk("dly_retired", 32'(retired_a), 32'd2);

    // 3: register-form MUL
    do_reset();
    load_a(16'h11C1, 16'hF000, 16'hF000);
    exp_wr.push_back(16'h11C1);
    n_wr0 = n_wr;
    pulse_start_a();
    wait_halt(50);
    chk("mul_writes", 32'(n_wr - n_wr0), 32'd1);
    chk("mul_nfetch", 32'(fcyc_q.size()), 32'd2);
    if (fcyc_q.size() >= 2) chk("mul_span", 32'(fcyc_q[1] - fcyc_q[0]), 32'd5);
    chk("mul_sb_empty", 32'(exp_wr.size()), 32'd0);

    // 4: rst on the 2nd EXEC cycle of the MUL
    do_reset();
    n_wr0 = n_wr;
    pulse_start_a();  // FETCH
    tick();           // EXEC 1
    tick();           // EXEC 2
    chk("ab_in_exec", 32'({busy_a, ifa.imem_req}), 32'b10);
    rst = 1'b1;
    tick();
    chk("ab_busy",  32'(busy_a),       32'd0);
    chk("ab_pc",    32'(pc_a),         32'd0);
    chk("ab_ir",    32'(ir_a),         32'd0);
    chk("ab_req",   32'(ifa.imem_req), 32'd0);
    chk("ab_rf_we", 32'(rf_we_a),      32'd0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    chk("ab_no_write", 32'(n_wr - n_wr0), 32'd0);
    chk("ab_idle",     32'(busy_a),       32'd0);

    // 5: start in EXEC ignored, then start in HALT restarts at 0
    do_reset();
    exp_wr.push_back(16'h11C1);
    pulse_start_a();  // FETCH
    tick();           // EXEC 1
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("sx_still_exec", 32'({busy_a, ifa.imem_req}), 32'b10);
    wait_halt(50);
    chk("sx_nfetch", 32'(fcyc_q.size()), 32'd2);
    if (fcyc_q.size() >= 2) chk("sx_span", 32'(fcyc_q[1] - fcyc_q[0]), 32'd5);
    chk("sx_retired", 32'(retired_a), 32'd2);
    chk("sx_halt_pc", 32'(pc_a),      32'd1);
    exp_wr.push_back(16'h11C1);
    pulse_start_a();
    chk("rs_halted",  32'(halted_a),     32'd0);
    chk("rs_req",     32'(ifa.imem_req), 32'd1);
    chk("rs_pc",      32'(pc_a),         32'd0);
    chk("rs_retired", 32'(retired_a),    32'd2);
    wait_halt(50);
    chk("rs_retired2", 32'(retired_a),     32'd4);
    chk("rs_sb_empty", 32'(exp_wr.size()), 32'd0);

    // 6: PCW=2 wrap with four writing words
    mem_b[0] = 16'h2101; mem_b[1] = 16'h2102; mem_b[2] = 16'h2103; mem_b[3] = 16'h2104;
    do_reset();
    bwr = 0;
    bprev = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 60 && bpcs.size() < 5; i++) begin
      if (ifb.imem_req && !bprev) begin
        bpcs.push_back(int'(pc_b));
        if (bpcs.size() == 5) chk("wrap_retired", 32'(retired_b), 32'd4);
      end
      if (rf_we_b) bwr++;
      bprev = ifb.imem_req;
      if (bpcs.size() < 5) tick();
    end
    chk("wrap_nfetch", 32'(bpcs.size()), 32'd5);
    if (bpcs.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("wrap_pc", 32'(bpcs[i]), 32'(i % 4));
    end
    chk("wrap_writes", 32'(bwr), 32'd4);

    rst = 1'b1;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pu_seq.md
Name: pu_seq

Overview:
- Multi-cycle fetch/execute/writeback sequencer for the 16-bit PU.
- Owns the PC and the instruction register (IR); drives the decoder input from IR.
- Gates the decoder's register-file write enable so that a write happens exactly once per instruction.
- Stretches the execute phase for MUL and stops the machine on HALT.

Parameters:
- PCW, 8, PC / instruction-address width.
- CMDW, 16, instruction width; must equal the decoder input width.
- MULLAT, 3, EXEC cycles for register-form MUL; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  single-cycle pulse that begins execution; sampled only in IDLE and HALT.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PCW  fetch address; always equal to pc.
- imem_rdy  in  1  fetch data valid this cycle.
- imem_data  in  CMDW  fetched instruction.
- ir  out  CMDW  instruction register; connected to the decoder instruction input.
- dec_h  in  1  HALT flag from the decoder.
- dec_we  in  1  write enable from the decoder.
- rf_we  out  1  gated register-file write enable.
- pc  out  PCW  program counter.
- busy  out  1  high in FETCH, EXEC and WB.
- halted  out  1  high in HALT.
- retired  out  16  count of completed instructions, HALT included.

Behaviour:
- States: IDLE, FETCH, EXEC, WB, HALT; 3-bit state register.
- Reset values: state=IDLE, pc=0, ir=0 (decodes as NOP), mul counter=0, retired=0.
- Reset output values: imem_req=0, rf_we=0, busy=0, halted=0.
- rst asserted in any state, mid-fetch or mid-MUL included, aborts at the next edge.
  - No write is issued after that edge.
  - The outstanding fetch is dropped; imem_rdy arriving afterwards is ignored.
- Output decode:
  - imem_req = (state==FETCH).
  - rf_we = (state==WB) & dec_we & ~dec_h; combinational from state plus decoder outputs.
  - busy = FETCH|EXEC|WB.
  - halted = (state==HALT).
- IDLE:
  - start=1 -> FETCH.
  - Otherwise hold.
- FETCH:
  - imem_req is held high until imem_rdy=1; a wait of any length is legal.
  - On imem_rdy=1: ir<=imem_data and go to EXEC. Same-cycle ready is allowed.
  - On entering EXEC, load the mul counter:
    - MULLAT-1 when the fetched word has [15:12]=4'b0001 and [7:4]=4'b1100 (register-form MUL);
    - 0 otherwise.
- EXEC:
  - IR is stable; the decoder and ALU evaluate combinationally.
  - Counter !=0: decrement and stay.
  - Counter ==0: go to WB.
  - EXEC therefore lasts MULLAT cycles for MUL and 1 cycle for everything else. Immediate-form CAL, LI, LIL, LIH and NOP take 1 cycle.
- WB, exactly one cycle:
  - retired<=retired+1, saturating at 16'hFFFF.
  - dec_h=1: pc unchanged, rf_we=0, go to HALT.
  - Otherwise: pc<=pc+1 and go to FETCH. pc wraps from 2^PCW-1 to 0 silently.
- HALT:
  - Hold; pc stays pointing at the HALT word.
  - start=1: pc<=0 and go to FETCH; halted drops on that edge.
  - retired is not cleared; only rst clears it.
- start in FETCH, EXEC or WB is ignored.
- Latency:
  - Non-MUL instruction with zero-wait memory: 3 cycles from the FETCH entry edge to the next FETCH entry.
  - MUL: 2+MULLAT cycles.
  - Each imem wait cycle adds 1.
- Exactly one rf_we pulse per writing instruction, always in WB. No writes occur in FETCH, EXEC, IDLE or HALT.
- imem_data is sampled only when imem_req & imem_rdy.

Test Plan:
- Reset, then start with zero-wait memory and program {LI r1,5; NOP; HALT} -> pc advances 0,1,2 and stops at 2.
  - rf_we pulses once, in the first WB, with ir=16'h2105.
  - halted=1 and retired=3.
- Fetch ready delayed 4 cycles on address 0 -> imem_req stays high for 5 cycles with imem_addr=0; ir loads only on the rdy cycle.
- Register-form MUL 16'h11C1 with MULLAT=3 -> EXEC holds 3 cycles, then a single rf_we pulse in WB; the instruction spans 5 cycles total.
- rst asserted on the 2nd EXEC cycle of that MUL -> after the edge: state IDLE, pc=0, ir=0, rf_we never pulsed.
- PCW=2, program of four non-HALT words -> pc sequence 0,1,2,3,0; fetch resumes at 0 and retired=4 after the wrap.
- start pulsed in EXEC is ignored (no state change). start pulsed in HALT -> pc=0, FETCH next cycle, halted=0, retired keeps its prior value.
